// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter
//   Shares one 2:1 mux output between two requesters. Round-robin arbitration
//   with break-before-make dead time: when ownership changes, out_enable drops
//   and select moves first, then the new grant follows DEAD_CYCLES cycles
//   later, so the downstream glitch_mux never switches while its output is
//   enabled. MAX_HOLD optionally bounds how long a holder can keep the output
//   while the other side is waiting.
//
// Ports
//   clk         in   1  system clock, all logic on posedge
//   rst         in   1  synchronous reset, active-low
//   req         in   2  req[i]=1: requester i wants the mux output
//   gnt         out  2  one-hot or zero; gnt[i]=1: requester i owns output
//   select      out  1  mux select (0 -> in0/requester 0, 1 -> in1)
//   out_enable  out  1  1 only in GRANT; gates the mux output downstream
//   busy        out  1  1 whenever the arbiter is not idle
module mux_share_arbiter #(
    parameter int DEAD_CYCLES = 2,
    parameter int MAX_HOLD    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       select,
    output logic       out_enable,
    output logic       busy
);

    localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    localparam logic [DW-1:0] DEAD_INIT = DW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GRANT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;   // SETTLE target or GRANT holder
    logic            last_q, last_d;     // most recent holder, loses the next tie
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic            select_d;
    logic            other;
    logic            contested;
    logic            forced;

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        dcnt_d    = dcnt_q;
        hcnt_d    = hcnt_q;
        select_d  = select;
        other     = ~owner_q;
        contested = req[other];
        forced    = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d  = (req == 2'b11) ? ~last_q : req[1];
                    select_d = owner_d;
                    if (DEAD_CYCLES > 0) begin
                        state_d = SETTLE;
                        dcnt_d  = DEAD_INIT;
                    end else begin
                        state_d = GRANT;
                        last_d  = owner_d;
                        hcnt_d  = '0;
                    end
                end
            end

            SETTLE: begin
                // A vanished request aborts the handover; last is untouched so
                // the aborted side still wins the next tie.
                if (!req[owner_q]) begin
                    state_d = IDLE;
                end else if (dcnt_q == '0) begin
                    state_d = GRANT;
                    last_d  = owner_q;
                    hcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q - 1'b1;
                end
            end

            GRANT: begin
                if (hcnt_q != HOLD_MAX) begin
                    hcnt_d = hcnt_q + 1'b1;
                end
                // Compare with >= so a holder that was uncontested past the
                // limit is released as soon as the other side asks.
                forced = (MAX_HOLD != 0) && contested && (hcnt_q >= HOLD_LAST);
                if (!req[owner_q] || forced) begin
                    if (contested && (DEAD_CYCLES > 0)) begin
                        state_d  = SETTLE;
                        owner_d  = other;
                        select_d = other;
                        dcnt_d   = DEAD_INIT;
                    end else begin
                        // Without dead time, pass through IDLE so select never
                        // moves while out_enable is high; the IDLE tie-break
                        // then hands over to the waiting side.
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: outputs are registered from the next-state values, so gnt,
    // out_enable and busy always change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            dcnt_q     <= '0;
            hcnt_q     <= '0;
            gnt        <= 2'b00;
            select     <= 1'b0;
            out_enable <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            dcnt_q     <= dcnt_d;
            hcnt_q     <= hcnt_d;
            gnt        <= (state_d == GRANT) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
            select     <= select_d;
            out_enable <= (state_d == GRANT);
            busy       <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb_mux_share_arbiter
//   Directed bench for mux_share_arbiter with DEAD_CYCLES=2, MAX_HOLD=4.
//   Inputs change 1 ns after a rising edge and outputs are read at that same
//   point, so each step() observes the result of exactly one edge. The grant
//   rises on the second edge after the IDLE edge that first sees the request
//   (third edge counting that one).
module tb_mux_share_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       select;
    logic       out_enable;
    logic       busy;

    int   total = 0;
    int   bad   = 0;
    logic inv_on = 1'b0;
    logic prev_oe;
    logic prev_sel;

    mux_share_arbiter #(
        .DEAD_CYCLES(2),
        .MAX_HOLD   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .select    (select),
        .out_enable(out_enable),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare {gnt, select, out_enable, busy} against hand-computed values.
    task automatic check(input string tag, input logic [1:0] eg, input logic es,
                         input logic eo, input logic eb);
        logic [4:0] obs;
        logic [4:0] exp;
        obs = {gnt, select, out_enable, busy};
        exp = {eg, es, eo, eb};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: gnt/sel/oe/busy observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one edge and check the every-cycle invariants.
    task automatic step();
        @(posedge clk);
        #1;
        if (inv_on) begin
            total++;
            assert ((gnt & (gnt - 2'd1)) === 2'b00) else begin
                bad++;
                $error("FAIL onehot: gnt observed=%b expected one-hot or zero", gnt);
            end
            total++;
            assert ((prev_oe && out_enable && (select != prev_sel)) === 1'b0) else begin
                bad++;
                $error("FAIL sel_stable: select observed=%b expected=%b while out_enable=1",
                       select, prev_sel);
            end
        end
        prev_oe  = out_enable;
        prev_sel = select;
    endtask

    initial begin
        // 1: reset with both requests up
        rst = 1'b0;
        req = 2'b11;
        step();
        step();
        check("reset", 2'b00, 1'b0, 1'b0, 1'b0);
        inv_on = 1'b1;

        // 2: single request from IDLE, then release
        rst = 1'b1;
        req = 2'b01;
        step();
        check("single_e1", 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        check("single_e2", 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        check("single_grant", 2'b01, 1'b0, 1'b1, 1'b1);
        req = 2'b00;
        step();
        check("single_release", 2'b00, 1'b0, 1'b0, 1'b0);

        // 3: tie from reset goes to req0, then hand over to req1
        rst = 1'b0;
        step();
        rst = 1'b1;
        req = 2'b11;
        step();
        check("tie_settle", 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        step();
        check("tie_grant0", 2'b01, 1'b0, 1'b1, 1'b1);
        req = 2'b10;
        step();
        check("alt_dead1", 2'b00, 1'b1, 1'b0, 1'b1);
        step();
        check("alt_dead2", 2'b00, 1'b1, 1'b0, 1'b1);
        step();
        check("alt_grant1", 2'b10, 1'b1, 1'b1, 1'b1);

        // 4: forced release after MAX_HOLD contested cycles
        req = 2'b00;
        step();
        check("idle_sel_held", 2'b00, 1'b1, 1'b0, 1'b0);
        req = 2'b01;
        step();
        check("pre_settle", 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        step();
        check("pre_grant0", 2'b01, 1'b0, 1'b1, 1'b1);
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("pre_hold%0d", i + 2), 2'b01, 1'b0, 1'b1, 1'b1);
        end
        step();
        check("pre_release", 2'b00, 1'b1, 1'b0, 1'b1);
        step();
        check("pre_dead2", 2'b00, 1'b1, 1'b0, 1'b1);
        step();
        check("pre_grant1", 2'b10, 1'b1, 1'b1, 1'b1);
        req = 2'b00;
        step();
        check("pre_idle", 2'b00, 1'b1, 1'b0, 1'b0);
        req = 2'b11;
        step();
        check("pre_tie_to0", 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        step();
        check("pre_tie_grant0", 2'b01, 1'b0, 1'b1, 1'b1);
        req = 2'b00;
        step();
        check("pre_tie_idle", 2'b00, 1'b0, 1'b0, 1'b0);

        // 5: abort during SETTLE leaves last unchanged
        req = 2'b10;
        step();
        check("abort_settle", 2'b00, 1'b1, 1'b0, 1'b1);
        req = 2'b00;
        step();
        check("abort_idle", 2'b00, 1'b1, 1'b0, 1'b0);
        req = 2'b11;
        step();
        check("abort_tie_to1", 2'b00, 1'b1, 1'b0, 1'b1);
        step();
        step();
        check("abort_tie_grant1", 2'b10, 1'b1, 1'b1, 1'b1);

        // 6: reset while req1 holds the output
        rst = 1'b0;
        step();
        check("reset_mid_grant", 2'b00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        req = 2'b00;
        step();
        check("post_reset_idle", 2'b00, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
